// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store controller between the execute stage and a word-addressed,
// combinational-read data memory. Translates RV32I LB/LH/LW/LBU/LHU/SB/SH/SW
// requests into word accesses. Sub-word stores use read-modify-write. Loads are
// sign- or zero-extended. Faulting requests never strobe the memory.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE, not in reset)
//   req_we, req_funct3        store/load select and RV32I access size/sign
//   req_addr, req_wdata       byte address and store data
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_fault    extended load data / fault flag, held until next resp
//   mem_read_en/mem_write_en  data memory strobes (never both high)
//   mem_address, mem_wdata    word-aligned address and write data to memory
//   mem_rdata                 combinational read data from memory
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
   parameter int unsigned DEPTH_WORDS = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_read_en,
   output logic        mem_write_en,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 30;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_RD,
      S_ST_WR,
      S_RMW_RD,
      S_RMW_WR,
      S_RESP
   } state_e;

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   merge_q, merge_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                resp_fault_q, resp_fault_d;

   logic                f3_ok_c;
   logic                misalign_c;
   logic                oor_c;
   logic                req_fault_c;
   logic [7:0]          ld_byte_c;
   logic [15:0]         ld_half_c;
   logic [DATA_W-1:0]   ld_ext_c;
   logic [DATA_W-1:0]   merge_wdata_c;

   // Request legality, evaluated on the raw request at acceptance
   always_comb begin
      if (req_we) begin
         f3_ok_c = (req_funct3 inside {3'b000, 3'b001, 3'b010});
      end else begin
         f3_ok_c = !(req_funct3 inside {3'b011, 3'b110, 3'b111});
      end
      misalign_c  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      oor_c       = (req_addr[31:2] >= IDX_W'(DEPTH_WORDS));
      req_fault_c = !f3_ok_c || misalign_c || oor_c;
   end

   // Lane extraction and extension of the word being read for a load
   always_comb begin
      ld_byte_c = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
      ld_half_c = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q[1:0])
         2'b00:   ld_ext_c = {{24{~funct3_q[2] & ld_byte_c[7]}}, ld_byte_c};
         2'b01:   ld_ext_c = {{16{~funct3_q[2] & ld_half_c[15]}}, ld_half_c};
         default: ld_ext_c = mem_rdata;
      endcase
   end

   // Merge the store lane into the word captured during RMW_RD
   always_comb begin
      merge_wdata_c = merge_q;
      if (funct3_q[0]) begin
         merge_wdata_c[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end else begin
         merge_wdata_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         addr_q       <= '0;
         wdata_q      <= '0;
         merge_q      <= '0;
         resp_rdata_q <= '0;
         resp_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         merge_q      <= merge_d;
         resp_rdata_q <= resp_rdata_d;
         resp_fault_q <= resp_fault_d;
      end
   end

   // Next-state, strobes and response updates
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      merge_d      = merge_q;
      resp_rdata_d = resp_rdata_q;
      resp_fault_d = resp_fault_q;
      req_ready    = 1'b0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      mem_wdata    = '0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (req_fault_c) begin
                  resp_fault_d = 1'b1;
                  resp_rdata_d = '0;
                  state_d      = S_RESP;
               end else if (!req_we) begin
                  state_d = S_LD_RD;
               end else if (req_funct3 == 3'b010) begin
                  state_d = S_ST_WR;
               end else begin
                  state_d = S_RMW_RD;
               end
            end
         end
         S_LD_RD: begin
            mem_read_en  = 1'b1;
            resp_rdata_d = ld_ext_c;
            resp_fault_d = 1'b0;
            state_d      = S_RESP;
         end
         S_ST_WR: begin
            mem_write_en = 1'b1;
            mem_wdata    = wdata_q;
            resp_rdata_d = '0;
            resp_fault_d = 1'b0;
            state_d      = S_RESP;
         end
         S_RMW_RD: begin
            mem_read_en = 1'b1;
            merge_d     = mem_rdata;
            state_d     = S_RMW_WR;
         end
         S_RMW_WR: begin
            mem_write_en = 1'b1;
            mem_wdata    = merge_wdata_c;
            resp_rdata_d = '0;
            resp_fault_d = 1'b0;
            state_d      = S_RESP;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Reset suppresses handshake and any in-flight memory write
      if (rst) begin
         req_ready    = 1'b0;
         mem_read_en  = 1'b0;
         mem_write_en = 1'b0;
      end
   end

   assign resp_valid  = (state_q == S_RESP);
   assign resp_rdata  = resp_rdata_q;
   assign resp_fault  = resp_fault_q;
   assign mem_address = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Scoreboard bench for lsu_mem_ctrl: a 128-word memory model is attached to the
// memory port, a reference copy of memory predicts every response at issue
// time, and responses are popped and compared as resp_valid pulses.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

   localparam int unsigned DEPTH = 128;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic        pl_en  = 1'b0;
   logic        mem_clr = 1'b1;
   logic [6:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   bit          busy = 0;
   bit          flt_inflight = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.DEPTH_WORDS(DEPTH)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_fault   (resp_fault),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   // Data memory model: combinational read, write only when not also reading
   assign mem_rdata = mem[mem_address[8:2]];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_clr) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h0;
      end else if (pl_en) begin
         mem[pl_idx] <= pl_val;
      end else if (mem_write_en && !mem_read_en) begin
         mem[mem_address[8:2]] <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic set_word(input int idx, input logic [31:0] val);
      @(negedge clk);
      pl_en  = 1'b1;
      pl_idx = 7'(idx);
      pl_val = val;
      ref_mem[idx] = val;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // Predict the response, then drive the request until it is accepted
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold);
      exp_t        e;
      logic        flt;
      logic [29:0] widx;
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      int          off;
      bit          acc_ok;
      widx = addr[31:2];
      off  = int'(addr[1:0]);
      case ({we, f3})
         4'b0000, 4'b0100, 4'b1000: flt = 1'b0;
         4'b0001, 4'b0101, 4'b1001: flt = addr[0];
         4'b0010, 4'b1010:          flt = (addr[1:0] != 2'b00);
         default:                   flt = 1'b1;
      endcase
      if (widx >= 30'(DEPTH)) flt = 1'b1;
      e.fault = flt;
      e.rdata = 32'h0;
      if (flt) begin
         e.lat = 1;
      end else if (!we) begin
         w = ref_mem[widx[6:0]];
         b = w[8*off +: 8];
         h = addr[1] ? w[31:16] : w[15:0];
         case (f3)
            3'b000:  e.rdata = {{24{b[7]}}, b};
            3'b100:  e.rdata = {24'h0, b};
            3'b001:  e.rdata = {{16{h[15]}}, h};
            3'b101:  e.rdata = {16'h0, h};
            default: e.rdata = w;
         endcase
         e.lat = 2;
      end else begin
         w = ref_mem[widx[6:0]];
         case (f3)
            3'b000:  begin w[8*off +: 8] = wd[7:0];              e.lat = 3; end
            3'b001:  begin w[16*(off/2) +: 16] = wd[15:0];       e.lat = 3; end
            default: begin w = wd;                               e.lat = 2; end
         endcase
         ref_mem[widx[6:0]] = w;
      end

      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      acc_ok     = 0;
      for (int i = 0; i < 40; i++) begin
         if (req_ready) begin
            acc_ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!acc_ok) begin
         chk("accept_timeout", 32'(acc_ok), 32'h1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e.acc = cyc;
      sb_q.push_back(e);
      busy         = 1;
      flt_inflight = flt;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (sb_q.size() != 0); i++) @(negedge clk);
      chk("drain", 32'(sb_q.size()), 32'h0);
   endtask

   // Response scoreboard and per-cycle protocol checks
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("rw_excl", 32'(mem_read_en & mem_write_en), 32'h0);
         if (busy) chk("ready_busy", 32'(req_ready), 32'h0);
         if (flt_inflight) chk("fault_strobe", 32'({mem_read_en, mem_write_en}), 32'h0);
         if (resp_valid) begin
            if (sb_q.size() == 0) begin
               chk("spurious_resp", 32'(resp_valid), 32'h0);
            end else begin
               e = sb_q.pop_front();
               chk("rdata", resp_rdata, e.rdata);
               chk("fault", 32'(resp_fault), 32'(e.fault));
               chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
            busy         = 0;
            flt_inflight = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_ready",      32'(req_ready),    32'h0);
      chk("rst_resp_valid", 32'(resp_valid),   32'h0);
      chk("rst_resp_fault", 32'(resp_fault),   32'h0);
      chk("rst_resp_rdata", resp_rdata,        32'h0);
      chk("rst_strobes",    32'({mem_read_en, mem_write_en}), 32'h0);
      mem_clr = 1'b0;
      rst     = 1'b0;
      #1 chk("ready_after_reset", 32'(req_ready), 32'h1);

      // Reset during the write phase of an SB must abort it cleanly
      set_word(1, 32'h11223344);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr  = 32'h4; req_wdata = 32'h000000AA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 chk("rmw_wr_strobe", 32'(mem_write_en), 32'h1);
      rst = 1'b1;
      #1 chk("rst_gates_write", 32'({mem_read_en, mem_write_en, req_ready}), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("ready_after_abort", 32'(req_ready), 32'h1);
      repeat (4) @(negedge clk);
      chk("abort_mem1", mem[1], 32'h11223344);

      // SW then LW
      issue(1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 0);
      issue(1'b0, 3'b010, 32'h0, 32'h0, 0);
      drain();

      // SB into byte 1 of word 1
      issue(1'b1, 3'b000, 32'h5, 32'h000000AB, 0);
      drain();
      chk("sb_mem1", mem[1], 32'h1122AB44);

      // SH into upper half of word 2
      set_word(2, 32'hCAFEF00D);
      issue(1'b1, 3'b001, 32'hA, 32'h12345678, 0);
      drain();
      chk("sh_mem2", mem[2], 32'h5678F00D);

      // Sub-word load extension
      set_word(1, 32'h80FF0000);
      issue(1'b0, 3'b000, 32'h6, 32'h0, 0);
      issue(1'b0, 3'b100, 32'h6, 32'h0, 0);
      issue(1'b0, 3'b001, 32'h6, 32'h0, 0);
      issue(1'b0, 3'b101, 32'h6, 32'h0, 0);
      issue(1'b0, 3'b000, 32'h7, 32'h0, 0);
      drain();

      // Faults: misaligned, out of range, illegal funct3
      issue(1'b0, 3'b001, 32'h3,   32'h0, 0);
      issue(1'b1, 3'b010, 32'h2,   32'hFFFFFFFF, 0);
      issue(1'b0, 3'b010, 32'h200, 32'h0, 0);
      issue(1'b0, 3'b011, 32'h0,   32'h0, 0);
      issue(1'b1, 3'b100, 32'h0,   32'h0, 0);
      drain();
      chk("fault_no_write", mem[0], 32'hDEADBEEF);

      // Back-to-back alternating LW/SB with req_valid held high
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 3'b010, {23'h0, 7'($urandom_range(0, 127)), 2'b00}, 32'h0, 1);
         issue(1'b1, 3'b000, {23'h0, 9'($urandom_range(0, 511))}, $urandom, 1);
      end
      @(negedge clk);
      req_valid = 1'b0;
      drain();
      for (int i = 0; i < int'(DEPTH); i += 16) chk("mem_final", mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller between the execute stage and the word-addressed data memory (128 x 32-bit, combinational read, write on posedge clk only when write_en && !read_en).
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Sub-word stores use read-modify-write, and loads are sign- or zero-extended.
- Misaligned, out-of-range and illegal-funct3 requests are flagged and never touch memory.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words in data memory; word index addr[31:2] >= DEPTH_WORDS is a fault.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and accepting a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte or half is used for SB/SH.
- resp_valid  out  1  one-cycle pulse when the request completes.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid; 1 = misaligned, out of range, or illegal funct3.
- mem_read_en  out  1  to data memory read_en.
- mem_write_en  out  1  to data memory write_en.
- mem_address  out  32  to data memory address; always {word_index, 2'b00}.
- mem_wdata  out  32  to data memory data_in.
- mem_rdata  in  32  from data memory data_out; combinational, same cycle.

Behaviour:
- Reset:
  - Synchronous active-high on the clk rising edge.
  - State := IDLE; resp_valid, resp_fault := 0; resp_rdata := 0; latched request regs := 0.
  - While rst = 1: req_ready = 0, mem_read_en = 0, mem_write_en = 0.
  - Reset mid-operation aborts the transaction: no write is issued and no response is produced. A write in RMW_WR or ST_WR during a cycle with rst = 1 is suppressed.
- Acceptance:
  - req_ready = (state == IDLE) && !rst.
  - Transfer occurs on an edge where req_valid && req_ready.
  - req_we, funct3, addr and wdata are latched at that edge; inputs are ignored outside IDLE.
- Fault check (decided at acceptance):
  - Illegal funct3: loads 011/110/111; stores any value other than 000/001/010.
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 0.
  - addr[31:2] >= DEPTH_WORDS.
  - A faulting request goes IDLE -> RESP with resp_fault = 1 and resp_rdata = 0; no memory strobe is asserted.
- States:
  - IDLE: no memory strobes.
  - LD_RD: mem_read_en = 1. At the end of the cycle, capture mem_rdata; extract byte addr[1:0] or half addr[1]; sign-extend (B, H) or zero-extend (BU, HU) into resp_rdata. Next state RESP.
  - ST_WR (SW only): mem_write_en = 1, mem_read_en = 0, mem_wdata = wdata. Next state RESP.
  - RMW_RD (SB/SH): mem_read_en = 1; capture mem_rdata into the merge register. Next state RMW_WR.
  - RMW_WR:
    - mem_write_en = 1, mem_read_en = 0.
    - mem_wdata is the merge word with the selected lane replaced.
    - SB lane: bits [8*addr[1:0] +: 8].
    - SH lane: bits [16*addr[1] +: 16].
    - Next state RESP.
  - RESP: resp_valid = 1 for exactly one cycle. Next state IDLE; a new request can be accepted from the following cycle.
- Latency (accept edge to resp_valid high):
  - Fault: 1 cycle.
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Back-to-back throughput is one request per latency + 1 cycles.
- Held outputs:
  - resp_rdata and resp_fault hold their values until the next RESP.
  - mem_address is held constant for the whole transaction.
- Memory strobes: mem_read_en and mem_write_en are never both 1 in the same cycle.

Test Plan:
- Reset pulse during RMW_WR of SB 0x04 (mem[1] = 0x11223344):
  - mem[1] stays 0x11223344.
  - No resp_valid.
  - req_ready = 1 the cycle after rst drops.
- SW addr 0x00, wdata 0xDEADBEEF, then LW 0x00:
  - Store resp_valid on edge+2 with resp_fault = 0.
  - Load resp_rdata = 0xDEADBEEF.
- mem[1] = 0x11223344; SB addr 0x05, wdata 0x000000AB:
  - mem[1] = 0x1122AB44.
  - resp_valid exactly 3 cycles after acceptance.
- mem[1] = 0x80FF0000 (address 0x04 holds this word):
  - LB 0x06 -> 0xFFFFFFFF.
  - LBU 0x06 -> 0x000000FF.
  - LH 0x06 -> 0xFFFF80FF.
  - LHU 0x06 -> 0x000080FF.
- Fault cases, each giving resp_fault = 1 on edge+1 with zero memory strobes:
  - LH at 0x03.
  - SW at 0x02.
  - LW at 0x200 (word index 128).
  - Load with funct3 = 011.
- Hold req_valid high with alternating LW and SB requests:
  - req_ready is low during every non-IDLE state.
  - No request is dropped or duplicated.
  - mem_read_en && mem_write_en is never observed.
